// File: rtl/nfc_pkg.sv
// NFC command dispatch shared types: status codes, FSM states,
// queued command entry layout and the forced-fail status byte.
package nfc_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_WAIT  = 2'b10;
  localparam logic [1:0] ST_READY = 2'b11;

  localparam logic [7:0] SR_FAIL = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_WAIT,
    S_READY
  } state_t;

  typedef struct packed {
    logic [47:0] lba;
    logic [23:0] len;
    logic [15:0] opcode;
  } cmd_t;

  function automatic logic [1:0] st_code(input state_t s);
    logic [1:0] c;
    c = ST_IDLE;
    unique case (s)
      S_ISSUE: c = ST_BUSY;
      S_BUSY:  c = ST_BUSY;
      S_WAIT:  c = ST_WAIT;
      S_READY: c = ST_READY;
      default: c = ST_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/nfc_cmd_fifo.sv
// DEPTH x 88 command FIFO. Ports: clk/rst_n, push/din, pop/dout,
// count/empty, ovf_set (push refused because full before any pop).
module nfc_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [87:0]              din,
  input  logic                     pop,
  output logic [87:0]              dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     ovf_set
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [87:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  // fullness is judged before a same-cycle pop frees a slot
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign ovf_set = push && full;
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/nfc_cmd_dispatch.sv
// Queues register-file commands and issues them one at a time to the
// NAND core, tracking bus phase and R/B# wait; reports o_sr_0/o_status_0.
module nfc_cmd_dispatch
  import nfc_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TWB_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  input  logic [47:0]            nfc_lba,
  input  logic [23:0]            nfc_len,
  input  logic [15:0]            nfc_opcode,
  input  logic                   nfc_valid,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [47:0]            cmd_lba,
  output logic [23:0]            cmd_len,
  output logic [15:0]            cmd_opcode,
  input  logic                   ctrl_done,
  input  logic                   ctrl_sr_valid,
  input  logic [7:0]             ctrl_sr,
  input  logic                   rb_n,
  output logic [7:0]             o_sr_0,
  output logic [1:0]             o_status_0,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   ovf,
  output logic                   err_timeout,
  input  logic                   err_clr
);

  localparam logic [7:0]  TWB_LD   = 8'(TWB_CYCLES);
  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);

  logic        clk;
  logic        rst_n;
  logic        rb_m;
  logic        rb_s;
  logic [87:0] f_dout;
  logic        f_empty;
  logic        f_ovf;
  cmd_t        head;
  state_t      state;
  state_t      state_d;
  logic [7:0]  twb_cnt;
  logic [7:0]  twb_d;
  logic [23:0] tmo_cnt;
  logic [23:0] tmo_d;
  logic        pop;
  logic        tmo_hit;
  logic        sr_take;

  assign clk   = S_AXI_ACLK;
  assign rst_n = S_AXI_ARESETN;
  assign head  = f_dout;

  nfc_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (nfc_valid),
    .din     ({nfc_lba, nfc_len, nfc_opcode}),
    .pop     (pop),
    .dout    (f_dout),
    .count   (q_count),
    .empty   (f_empty),
    .ovf_set (f_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_m <= 1'b1;
      rb_s <= 1'b1;
    end else begin
      rb_m <= rb_n;
      rb_s <= rb_m;
    end
  end

  // decoded from the state flop so reset drops it without an edge
  assign cmd_valid = (state == S_ISSUE);

  assign sr_take = ctrl_sr_valid &&
                   (state == S_BUSY || state == S_WAIT);

  always_comb begin
    state_d = state;
    twb_d   = twb_cnt;
    tmo_d   = tmo_cnt;
    pop     = 1'b0;
    tmo_hit = 1'b0;
    unique case (state)
      S_IDLE, S_READY: begin
        if (!f_empty) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (ctrl_done) begin
          state_d = S_WAIT;
          twb_d   = TWB_LD;
          tmo_d   = '0;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_cnt + 24'd1;
        if (twb_cnt != 8'd0) twb_d = twb_cnt - 8'd1;
        // real completion beats a coincident timeout
        if (twb_cnt == 8'd0 && rb_s) begin
          state_d = S_READY;
        end else if (tmo_cnt == TMO_LAST) begin
          state_d = S_READY;
          tmo_hit = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      twb_cnt     <= '0;
      tmo_cnt     <= '0;
      o_status_0  <= ST_IDLE;
      o_sr_0      <= '0;
      cmd_lba     <= '0;
      cmd_len     <= '0;
      cmd_opcode  <= '0;
      ovf         <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state      <= state_d;
      twb_cnt    <= twb_d;
      tmo_cnt    <= tmo_d;
      o_status_0 <= st_code(state_d);
      if (tmo_hit)      o_sr_0 <= SR_FAIL;
      else if (sr_take) o_sr_0 <= ctrl_sr;
      if (pop) begin
        cmd_lba    <= head.lba;
        cmd_len    <= head.len;
        cmd_opcode <= head.opcode;
      end
      if (f_ovf)        ovf <= 1'b1;
      else if (err_clr) ovf <= 1'b0;
      if (tmo_hit)      err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nfc_cmd_dispatch.sv
// Directed bench for nfc_cmd_dispatch: table of full command
// transactions plus queue, overflow and reset corner sequences.
module tb_nfc_cmd_dispatch;

  logic        S_AXI_ACLK = 1'b0;
  logic        S_AXI_ARESETN;
  logic [47:0] nfc_lba;
  logic [23:0] nfc_len;
  logic [15:0] nfc_opcode;
  logic        nfc_valid;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [47:0] cmd_lba;
  logic [23:0] cmd_len;
  logic [15:0] cmd_opcode;
  logic        ctrl_done;
  logic        ctrl_sr_valid;
  logic [7:0]  ctrl_sr;
  logic        rb_n;
  logic [7:0]  o_sr_0;
  logic [1:0]  o_status_0;
  logic [2:0]  q_count;
  logic        ovf;
  logic        err_timeout;
  logic        err_clr;

  int checks   = 0;
  int failures = 0;

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  nfc_cmd_dispatch #(
    .DEPTH          (4),
    .TWB_CYCLES     (8),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .S_AXI_ACLK    (S_AXI_ACLK),
    .S_AXI_ARESETN (S_AXI_ARESETN),
    .nfc_lba       (nfc_lba),
    .nfc_len       (nfc_len),
    .nfc_opcode    (nfc_opcode),
    .nfc_valid     (nfc_valid),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_lba       (cmd_lba),
    .cmd_len       (cmd_len),
    .cmd_opcode    (cmd_opcode),
    .ctrl_done     (ctrl_done),
    .ctrl_sr_valid (ctrl_sr_valid),
    .ctrl_sr       (ctrl_sr),
    .rb_n          (rb_n),
    .o_sr_0        (o_sr_0),
    .o_status_0    (o_status_0),
    .q_count       (q_count),
    .ovf           (ovf),
    .err_timeout   (err_timeout),
    .err_clr       (err_clr)
  );

  typedef struct {
    logic [47:0] lba;
    logic [23:0] len;
    logic [15:0] op;
    logic [7:0]  sr;
    int          rb_low;
    int          wmin;
    int          wmax;
    logic [7:0]  exp_sr;
    logic        exp_err;
  } vec_t;

  vec_t vt[4];

  task automatic tick;
    @(posedge S_AXI_ACLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d",
               nm, act, lo, hi);
    end
  endtask

  task automatic push(input logic [47:0] l, input logic [23:0] n,
                      input logic [15:0] o);
    nfc_lba    = l;
    nfc_len    = n;
    nfc_opcode = o;
    nfc_valid  = 1'b1;
    tick();
    nfc_valid  = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!cmd_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (o_status_0 !== 2'b11 && n < 400) begin
      tick();
      n++;
    end
    chk(nm, o_status_0, 2'b11);
  endtask

  initial begin
    int lat;
    int n;

    vt[0] = '{48'h0000_1234_5678, 24'h000800, 16'h0030, 8'hE0,
              20, 22, 23, 8'hE0, 1'b0};
    vt[1] = '{48'hFFFF_FFFF_FFFF, 24'hFFFFFF, 16'hFFFF, 8'hE1,
              0, 8, 9, 8'hE1, 1'b0};
    vt[2] = '{48'hA5A5_0000_0001, 24'h000001, 16'h0060, 8'hC0,
              150, 100, 100, 8'h01, 1'b1};
    vt[3] = '{48'h0000_0000_0000, 24'h000000, 16'h0070, 8'hE0,
              5, 8, 9, 8'hE0, 1'b0};

    S_AXI_ARESETN = 1'b0;
    nfc_lba       = '0;
    nfc_len       = '0;
    nfc_opcode    = '0;
    nfc_valid     = 1'b0;
    cmd_ready     = 1'b0;
    ctrl_done     = 1'b0;
    ctrl_sr_valid = 1'b0;
    ctrl_sr       = '0;
    rb_n          = 1'b1;
    err_clr       = 1'b0;

    repeat (3) tick();
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_status", o_status_0, 2'b00);
    chk("rst_sr", o_sr_0, 8'h00);
    chk("rst_q_count", q_count, 3'd0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_err_timeout", err_timeout, 1'b0);
    S_AXI_ARESETN = 1'b1;
    tick();
    chk("idle_status", o_status_0, 2'b00);

    for (int k = 0; k < 4; k++) begin
      push(vt[k].lba, vt[k].len, vt[k].op);
      wait_valid(lat);
      chk("issue_latency", lat + 1, 2);
      chk("cmd_lba", cmd_lba, vt[k].lba);
      chk("cmd_len", cmd_len, vt[k].len);
      chk("cmd_opcode", cmd_opcode, vt[k].op);
      chk("st_issue", o_status_0, 2'b01);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      chk("busy_valid", cmd_valid, 1'b0);
      chk("st_busy", o_status_0, 2'b01);
      ctrl_done     = 1'b1;
      ctrl_sr_valid = 1'b1;
      ctrl_sr       = vt[k].sr;
      rb_n          = (vt[k].rb_low == 0);
      tick();
      ctrl_done     = 1'b0;
      ctrl_sr_valid = 1'b0;
      chk("st_wait", o_status_0, 2'b10);
      n = 0;
      while (o_status_0 == 2'b10 && n < 300) begin
        if (n == vt[k].rb_low) rb_n = 1'b1;
        tick();
        n++;
      end
      rb_n = 1'b1;
      chk_rng("wait_cycles", n, vt[k].wmin, vt[k].wmax);
      chk("st_ready", o_status_0, 2'b11);
      chk("sr", o_sr_0, vt[k].exp_sr);
      chk("err_timeout", err_timeout, vt[k].exp_err);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("err_clr_tmo", err_timeout, 1'b0);
    end

    // queue depth and overflow with one command parked in ISSUE
    push(48'h100, 24'h10, 16'h0030);
    wait_valid(lat);
    chk("park_valid", cmd_valid, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      nfc_lba    = 48'(k);
      nfc_len    = 24'(k);
      nfc_opcode = 16'h0080;
      nfc_valid  = 1'b1;
      tick();
    end
    nfc_valid = 1'b0;
    chk("full_q_count", q_count, 3'd4);
    chk("full_ovf", ovf, 1'b1);
    chk("park_lba_stable", cmd_lba, 48'h100);
    ctrl_done = 1'b1;
    tick();
    ctrl_done = 1'b0;
    chk("done_in_issue", {o_status_0, cmd_valid}, 3'b011);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_cleared", ovf, 1'b0);

    // finish the parked command; push into full FIFO on the pop cycle
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    ctrl_done = 1'b1;
    rb_n      = 1'b0;
    tick();
    ctrl_done = 1'b0;
    repeat (12) tick();
    rb_n = 1'b1;
    wait_ready("park_ready");
    nfc_lba   = 48'h99;
    nfc_valid = 1'b1;
    tick();
    nfc_valid = 1'b0;
    chk("fullpop_q_count", q_count, 3'd3);
    chk("fullpop_ovf", ovf, 1'b1);
    chk("fullpop_valid", cmd_valid, 1'b1);

    for (int k = 1; k <= 4; k++) begin
      wait_valid(lat);
      chk("order_lba", cmd_lba, 64'(k));
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      ctrl_done = 1'b1;
      tick();
      ctrl_done = 1'b0;
      wait_ready("order_done");
    end
    chk("drain_q_count", q_count, 3'd0);
    chk("drain_valid", cmd_valid, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_cleared2", ovf, 1'b0);

    // reset while a command is offered and another is queued
    push(48'h200, 24'h1, 16'h0030);
    push(48'h201, 24'h1, 16'h0030);
    chk("pre_rst_valid", cmd_valid, 1'b1);
    chk("pushpop_q_count", q_count, 3'd1);
    #3;
    S_AXI_ARESETN = 1'b0;
    #1;
    chk("async_rst_valid", cmd_valid, 1'b0);
    chk("async_rst_q_count", q_count, 3'd0);
    chk("async_rst_status", o_status_0, 2'b00);
    @(posedge S_AXI_ACLK);
    #1;
    S_AXI_ARESETN = 1'b1;
    tick();
    chk("post_rst_valid", cmd_valid, 1'b0);
    chk("post_rst_q_count", q_count, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
